// File: rtl/ct_mmu_jtlb_data_arb.sv
// jTLB data array sequencer: arbitrates the single array port between lookup
// reads and refill writes, and runs a full-array invalidate sweep on request.

module ct_mmu_jtlb_data_arb_bank (
   input  logic       rd_sel_i,
   input  logic       wr_sel_i,
   input  logic       sweep_i,
   input  logic [1:0] wr_way_i,
   output logic       cen_o,
   output logic [1:0] wen_o
);
   // A bank is enabled for reads and sweeps, and for writes only when one of its ways is targeted.
   always_comb begin
      cen_o = rd_sel_i | sweep_i | (wr_sel_i & (|wr_way_i));
      wen_o = 2'b00;
      if (sweep_i)       wen_o = 2'b11;
      else if (wr_sel_i) wen_o = wr_way_i;
   end
endmodule

module ct_mmu_jtlb_data_arb (
   input  logic        forever_cpuclk_i,
   input  logic        cpurst_b_i,
   input  logic        rd_req_i,
   input  logic [7:0]  rd_idx_i,
   output logic        rd_gnt_o,
   output logic        rd_vld_o,
   output logic [83:0] rd_data0_o,
   output logic [83:0] rd_data1_o,
   input  logic        wr_req_i,
   input  logic [7:0]  wr_idx_i,
   input  logic [3:0]  wr_way_i,
   input  logic [41:0] wr_data_i,
   output logic        wr_gnt_o,
   input  logic        flush_req_i,
   output logic        flush_busy_o,
   output logic        flush_done_o,
   output logic        jtlb_data_cen0_o,
   output logic        jtlb_data_cen1_o,
   output logic [7:0]  jtlb_data_idx_o,
   output logic [3:0]  jtlb_data_wen_o,
   output logic [83:0] jtlb_data_din_o,
   input  logic [83:0] jtlb_data_dout0_i,
   input  logic [83:0] jtlb_data_dout1_i
);
   localparam int NUM_BANKS     = 2;
   localparam int WAYS_PER_BANK = 2;
   localparam int WAY_W         = 42;
   localparam int IDX_W         = 8;
   localparam logic [1:0] STARVE_MAX = 2'd2;

   typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

   typedef struct packed {
      logic [IDX_W-1:0]                     idx;
      logic [NUM_BANKS*WAYS_PER_BANK-1:0]   way;
      logic [WAY_W-1:0]                     data;
   } wr_req_t;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] fidx_q, fidx_d;
   logic [1:0]       starve_q, starve_d;
   logic             rd_vld_q;
   logic             flush_done_q, flush_done_d;

   logic             rd_sel, wr_sel, sweep;
   logic [NUM_BANKS-1:0] bank_cen;
   wr_req_t          wr_s;

   assign wr_s = '{idx: wr_idx_i, way: wr_way_i, data: wr_data_i};

   // State register
   always_ff @(posedge forever_cpuclk_i) begin
      if (!cpurst_b_i) begin
         state_q      <= S_IDLE;
         fidx_q       <= '0;
         starve_q     <= '0;
         rd_vld_q     <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fidx_q       <= fidx_d;
         starve_q     <= starve_d;
         rd_vld_q     <= rd_sel;
         flush_done_q <= flush_done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      fidx_d       = fidx_q;
      starve_d     = starve_q;
      flush_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush_req_i) begin
               state_d = S_FLUSH;
               fidx_d  = '0;
            end else if (rd_sel) begin
               starve_d = '0;
            end else if (wr_sel && rd_req_i && (starve_q != STARVE_MAX)) begin
               starve_d = starve_q + 2'd1;
            end
         end
         S_FLUSH: begin
            fidx_d = fidx_q + 8'd1;
            if (fidx_q == 8'hff) begin
               state_d      = S_IDLE;
               flush_done_d = 1'b1;
               starve_d     = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: a pending flush request blocks both requesters for its entry cycle.
   always_comb begin
      rd_sel = 1'b0;
      wr_sel = 1'b0;
      sweep  = 1'b0;
      if (cpurst_b_i) begin
         case (state_q)
            S_IDLE: begin
               if (!flush_req_i) begin
                  if (rd_req_i && (!wr_req_i || (starve_q == STARVE_MAX))) rd_sel = 1'b1;
                  else if (wr_req_i)                                         wr_sel = 1'b1;
               end
            end
            S_FLUSH: sweep = 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      ct_mmu_jtlb_data_arb_bank u_bank (
         .rd_sel_i (rd_sel),
         .wr_sel_i (wr_sel),
         .sweep_i  (sweep),
         .wr_way_i (wr_s.way[b*WAYS_PER_BANK +: WAYS_PER_BANK]),
         .cen_o    (bank_cen[b]),
         .wen_o    (jtlb_data_wen_o[b*WAYS_PER_BANK +: WAYS_PER_BANK])
      );
   end

   always_comb begin
      jtlb_data_idx_o = '0;
      jtlb_data_din_o = '0;
      if (rd_sel) begin
         jtlb_data_idx_o = rd_idx_i;
      end else if (wr_sel) begin
         jtlb_data_idx_o = wr_s.idx;
         jtlb_data_din_o = {wr_s.data, wr_s.data};
      end else if (sweep) begin
         jtlb_data_idx_o = fidx_q;
      end
   end

   assign jtlb_data_cen0_o = bank_cen[0];
   assign jtlb_data_cen1_o = bank_cen[1];
   assign rd_gnt_o         = rd_sel;
   assign wr_gnt_o         = wr_sel;
   assign rd_vld_o         = rd_vld_q;
   assign rd_data0_o       = jtlb_data_dout0_i;
   assign rd_data1_o       = jtlb_data_dout1_i;
   assign flush_busy_o     = (state_q == S_FLUSH);
   assign flush_done_o     = flush_done_q;

endmodule

// File: tb/tb_ct_mmu_jtlb_data_arb.sv
// Bench for ct_mmu_jtlb_data_arb: behavioural array plus a way-level reference
// store and grant policy model, checked every cycle.

module tb_ct_mmu_jtlb_data_arb;
   logic        clk = 1'b0;
   logic        rst_b;
   logic        rd_req, rd_gnt, rd_vld;
   logic [7:0]  rd_idx;
   logic [83:0] rd_data0, rd_data1;
   logic        wr_req, wr_gnt;
   logic [7:0]  wr_idx;
   logic [3:0]  wr_way;
   logic [41:0] wr_data;
   logic        flush_req, flush_busy, flush_done;
   logic        cen0, cen1;
   logic [7:0]  aidx;
   logic [3:0]  wen;
   logic [83:0] din;
   logic [83:0] dout0 = '0, dout1 = '0;

   always #5 clk = ~clk;

   ct_mmu_jtlb_data_arb dut (
      .forever_cpuclk_i  (clk),
      .cpurst_b_i        (rst_b),
      .rd_req_i          (rd_req),
      .rd_idx_i          (rd_idx),
      .rd_gnt_o          (rd_gnt),
      .rd_vld_o          (rd_vld),
      .rd_data0_o        (rd_data0),
      .rd_data1_o        (rd_data1),
      .wr_req_i          (wr_req),
      .wr_idx_i          (wr_idx),
      .wr_way_i          (wr_way),
      .wr_data_i         (wr_data),
      .wr_gnt_o          (wr_gnt),
      .flush_req_i       (flush_req),
      .flush_busy_o      (flush_busy),
      .flush_done_o      (flush_done),
      .jtlb_data_cen0_o  (cen0),
      .jtlb_data_cen1_o  (cen1),
      .jtlb_data_idx_o   (aidx),
      .jtlb_data_wen_o   (wen),
      .jtlb_data_din_o   (din),
      .jtlb_data_dout0_i (dout0),
      .jtlb_data_dout1_i (dout1)
   );

   // Single-port array driven purely by the DUT pins
   logic [83:0] arr0 [256];
   logic [83:0] arr1 [256];
   logic [83:0] row0, row1;
   always @(posedge clk) begin
      if (cen0) begin
         row0 = arr0[aidx];
         if (wen[1:0] == 2'b00) dout0 <= row0;
         else begin
            for (int w = 0; w < 2; w++) if (wen[w]) row0[w*42 +: 42] = din[w*42 +: 42];
            arr0[aidx] <= row0;
         end
      end
      if (cen1) begin
         row1 = arr1[aidx];
         if (wen[3:2] == 2'b00) dout1 <= row1;
         else begin
            for (int w = 0; w < 2; w++) if (wen[w+2]) row1[w*42 +: 42] = din[w*42 +: 42];
            arr1[aidx] <= row1;
         end
      end
   end

   // Reference: per-way contents and the arbitration rules
   logic [41:0] ref_mem [256][4];
   bit          m_flush, m_known, e_rdv, e_fdone, e_rg, e_wg;
   int          m_fidx, m_wcnt;
   logic [83:0] e_rd0, e_rd1;
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic       e_c0, e_c1;
      logic [3:0] e_wen;
      logic [7:0] e_idx;
      logic [83:0] e_din;
      #1;
      e_rg = 0; e_wg = 0; e_c0 = 0; e_c1 = 0; e_wen = '0; e_idx = '0; e_din = '0;
      if (rst_b) begin
         if (m_flush) begin
            e_c0 = 1; e_c1 = 1; e_wen = 4'hf; e_idx = m_fidx[7:0];
         end else if (!flush_req) begin
            if (rd_req && (!wr_req || m_wcnt >= 2)) e_rg = 1;
            else if (wr_req)                        e_wg = 1;
         end
         if (e_rg) begin e_c0 = 1; e_c1 = 1; e_idx = rd_idx; end
         if (e_wg) begin
            e_c0 = |wr_way[1:0]; e_c1 = |wr_way[3:2];
            e_wen = wr_way; e_idx = wr_idx; e_din = {wr_data, wr_data};
         end
      end
      chk("rd_gnt", 84'(rd_gnt), 84'(e_rg));
      chk("wr_gnt", 84'(wr_gnt), 84'(e_wg));
      chk("cen0",   84'(cen0),   84'(e_c0));
      chk("cen1",   84'(cen1),   84'(e_c1));
      chk("wen",    84'(wen),    84'(e_wen));
      if (rst_b) begin
         chk("idx", 84'(aidx), 84'(e_idx));
         chk("din", din, e_din);
      end
      if (m_known) begin
         chk("rd_vld",     84'(rd_vld),     84'(e_rdv));
         chk("flush_busy", 84'(flush_busy), 84'(m_flush));
         chk("flush_done", 84'(flush_done), 84'(e_fdone));
         if (e_rdv) begin
            chk("rd_data0", rd_data0, e_rd0);
            chk("rd_data1", rd_data1, e_rd1);
         end
      end
      @(posedge clk);
      if (!rst_b) begin
         m_flush = 0; m_fidx = 0; m_wcnt = 0; e_rdv = 0; e_fdone = 0; m_known = 1;
      end else begin
         e_rdv = e_rg;
         if (e_rg) begin
            e_rd0 = {ref_mem[rd_idx][1], ref_mem[rd_idx][0]};
            e_rd1 = {ref_mem[rd_idx][3], ref_mem[rd_idx][2]};
         end
         e_fdone = 0;
         if (e_wg) for (int w = 0; w < 4; w++) if (wr_way[w]) ref_mem[wr_idx][w] = wr_data;
         if (m_flush) begin
            for (int w = 0; w < 4; w++) ref_mem[m_fidx][w] = '0;
            if (m_fidx == 255) begin m_flush = 0; e_fdone = 1; m_wcnt = 0; end
            m_fidx = (m_fidx + 1) % 256;
         end else if (flush_req) begin
            m_flush = 1; m_fidx = 0;
         end
         if (e_rg) m_wcnt = 0;
         else if (e_wg && rd_req && m_wcnt < 2) m_wcnt++;
      end
      @(negedge clk);
   endtask

   task automatic rand_write(input bit any_way);
      logic [63:0] r64;
      r64 = {$urandom(), $urandom()};
      wr_data = r64[41:0];
      if (any_way) wr_way = 4'($urandom_range(15, 1));
      else         wr_way = 4'(1 << $urandom_range(3, 0));
   endtask

   initial begin
      logic [63:0] r64;
      bit rd_pend, wr_pend;
      for (int i = 0; i < 256; i++) begin
         for (int w = 0; w < 4; w++) begin
            r64 = {$urandom(), $urandom()};
            ref_mem[i][w] = r64[41:0];
         end
         arr0[i] = {ref_mem[i][1], ref_mem[i][0]};
         arr1[i] = {ref_mem[i][3], ref_mem[i][2]};
      end
      m_flush = 0; m_known = 0; m_fidx = 0; m_wcnt = 0; e_rdv = 0; e_fdone = 0;
      e_rd0 = '0; e_rd1 = '0;
      rst_b = 0; rd_req = 1; wr_req = 1; flush_req = 0;
      rd_idx = 8'h11; wr_idx = 8'h22; wr_way = 4'b0001; wr_data = '0;
      @(negedge clk);
      // Reset with both requesters active: nothing may be granted
      cycle(); cycle();
      rst_b = 1; rd_req = 0; wr_req = 0;
      cycle();

      // Single read of a preloaded index
      rd_req = 1; rd_idx = 8'h3c; cycle();
      rd_req = 0; cycle();

      // Write to way 2 then read it back
      wr_req = 1; wr_idx = 8'h05; wr_way = 4'b0100; wr_data = 42'h155; cycle();
      wr_req = 0; rd_req = 1; rd_idx = 8'h05; cycle();
      rd_req = 0;
      chk("way2_readback", 84'(rd_data1[41:0]), 84'(42'h155));
      cycle();

      // Both requesters held: W, W, R repeating
      rd_req = 1; wr_req = 1; rd_idx = 8'h40; wr_idx = 8'h41;
      for (int i = 0; i < 9; i++) begin
         rand_write(0);
         cycle();
      end
      rd_req = 0; wr_req = 0; cycle();

      // Same-index hazard: read in N, write same index in N+1
      rd_req = 1; rd_idx = 8'h20; cycle();
      rd_req = 0; wr_req = 1; wr_idx = 8'h20; rand_write(0); cycle();
      wr_req = 0; rd_req = 1; cycle();
      rd_req = 0; cycle();

      // Random traffic with requests held until granted
      rd_pend = 0; wr_pend = 0;
      for (int i = 0; i < 80; i++) begin
         if (!rd_pend && $urandom_range(1, 0) == 1) begin
            rd_pend = 1; rd_idx = 8'($urandom_range(15, 0));
         end
         if (!wr_pend && $urandom_range(1, 0) == 1) begin
            wr_pend = 1; wr_idx = 8'($urandom_range(15, 0));
            rand_write($urandom_range(7, 0) == 0);
         end
         rd_req = rd_pend; wr_req = wr_pend;
         cycle();
         if (e_rg) rd_pend = 0;
         if (e_wg) wr_pend = 0;
      end
      rd_req = 0; wr_req = 0; cycle();

      // Flush right after a read, with both requesters held
      rd_req = 1; rd_idx = 8'h7e; cycle();
      flush_req = 1; wr_req = 1; wr_idx = 8'h90; rand_write(0); cycle();
      flush_req = 0;
      for (int i = 0; i < 260; i++) begin
         flush_req = (i == 50);
         cycle();
      end
      flush_req = 0; wr_req = 0;
      for (int i = 0; i < 3; i++) cycle();
      rd_req = 0; cycle();
      for (int i = 0; i < 4; i++) begin
         rd_req = 1; rd_idx = 8'($urandom_range(255, 0)); cycle();
         rd_req = 0; cycle();
      end

      // Reset in the middle of a sweep
      flush_req = 1; cycle();
      flush_req = 0; rd_req = 1; wr_req = 1; wr_idx = 8'h63; rand_write(0); rd_idx = 8'h63;
      for (int i = 0; i < 100; i++) cycle();
      rst_b = 0; cycle(); cycle();
      rst_b = 1;
      for (int i = 0; i < 6; i++) cycle();
      rd_req = 0; wr_req = 0; cycle();
      for (int i = 99; i < 102; i++) begin
         rd_req = 1; rd_idx = 8'(i); cycle();
         rd_req = 0; cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
